control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Multi-cycle control unit driving the existing 8-bit datapath: consumes the 5-bit OpFn the datapath decodes and produces every datapath control strobe (NIA, RegDst, RegWrite, ALUSrc, ALUFn, MemWrite, MemRead, MemToReg).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Adds branch/jump qualification, a HALT state, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- OPW, 5, opcode/function field width; must match datapath OpFn.
- MEM_LAT, 1, cycles spent in MEM state (1..15).
- CNTW, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- OpFn  in  OPW  decoded opcode/function from datapath.
- alubeq  in  1  ALU equality flag; valid in EXEC.
- NIA  out  1  one-cycle PC advance strobe.
- Branch  out  1  PC loads branch target on NIA.
- Jump  out  1  PC loads jump target on NIA.
- RegDst  out  3  write-destination select: 001 = rd field, 010 = rb field, 000 = none.
- RegWrite  out  1  register file write enable.
- ALUSrc  out  1  0 = B register, 1 = sign-extended immediate.
- ALUFn  out  3  ALU function code.
- MemRead  out  1  data memory read enable.
- MemWrite  out  1  data memory write enable.
- MemToReg  out  1  1 = memory data to register file, 0 = ALU result.
- halted  out  1  high while in HALT.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- instr_count  out  CNTW  count of retired instructions.

Behaviour:
- Opcode map:
  - 00xxx: R-type ALU, ALUFn = OpFn[2:0] (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SHL 110, SHR 111).
  - 01000 ADDI; 01001 LW; 01010 SW; 01011 BEQ; 01100 JMP; 11111 HALT.
  - All other codes are illegal.
- Reset:
  - State = FETCH; op_q = 0; mem counter = 0; instr_count = 0.
  - All outputs are 0 in the cycle after rst is sampled high.
  - rst asserted mid-instruction aborts it: no NIA, no write.
- FETCH, 1 cycle: all strobes low; instruction memory output settles. Next state is DECODE.
- DECODE, 1 cycle:
  - OpFn is registered into op_q; all later states use op_q only.
  - Legal opcode: go to EXEC. HALT opcode: go to HALT.
  - Illegal opcode: illegal_op = 1 and NIA = 1 this cycle, instr_count += 1, next state FETCH. Behaves as a NOP.
- EXEC:
  - ALUFn and ALUSrc are driven. ALUSrc = 1 for ADDI/LW/SW, 0 otherwise.
  - ALUFn = ADD for ADDI/LW/SW, SUB for BEQ, don't-care 000 for JMP.
  - BEQ: Branch = alubeq, NIA = 1, next state FETCH.
  - JMP: Jump = 1, NIA = 1, next state FETCH.
  - LW/SW: next state MEM, with the mem counter loaded to MEM_LAT-1.
  - R/ADDI: next state WB.
- MEM:
  - LW holds MemRead = 1; SW holds MemWrite = 1. ALUFn/ALUSrc are held.
  - The counter decrements each cycle. Exit when the counter = 0: LW goes to WB; SW asserts NIA in the final cycle and goes to FETCH.
  - MemWrite is high for exactly MEM_LAT cycles.
- WB, 1 cycle:
  - RegWrite = 1 and NIA = 1.
  - R-type: RegDst = 001, MemToReg = 0.
  - ADDI: RegDst = 010, MemToReg = 0.
  - LW: RegDst = 010, MemToReg = 1, MemRead held.
  - Next state FETCH.
- Cycles per instruction: R/ADDI 4; LW 4+MEM_LAT; SW 3+MEM_LAT; BEQ/JMP 3; illegal 2.
- instr_count:
  - Increments by 1 in every cycle where NIA = 1.
  - Wraps from all-ones to 0 silently.
- HALT:
  - Terminal; halted = 1, all strobes 0, counter frozen.
  - Left only via rst.
- Invariants:
  - NIA is never high for two consecutive cycles.
  - RegWrite and MemWrite are never both high.
  - Branch and Jump are never both high.
- Outputs are a pure function of state, op_q and alubeq (Moore, plus alubeq for Branch). No output depends combinationally on OpFn except illegal_op/NIA in DECODE.

Decomposition:
- Package ctrl_pkg:
  - State enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
  - Opcode constants (OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT).
  - ALU function codes.
  - RegDst codes (RD_NONE, RD_RD, RD_RB).
- One sub-module, ctrl_decode: combinational op_q → instruction class (RTYPE/ADDI/LW/SW/BEQ/JMP/HALT/ILLEGAL) plus ALUFn. The FSM and counters stay in control_fsm.

Test Plan:
- Reset, then OpFn = 00001 (SUB) → DECODE, EXEC with ALUFn = 001, ALUSrc = 0; WB with RegWrite = 1, RegDst = 001, NIA = 1 in cycle 4; instr_count = 1.
- MEM_LAT = 3, OpFn = 01001 (LW) → MemRead high for 4 cycles (3 MEM + WB); WB has MemToReg = 1, RegDst = 010; total 7 cycles.
- OpFn = 01011 (BEQ) with alubeq = 1, then again with alubeq = 0 → EXEC shows Branch = 1 / Branch = 0, NIA = 1 in cycle 3 in both cases, RegWrite = 0.
- OpFn = 10101 (illegal) → illegal_op and NIA pulse in DECODE (cycle 2), no writes, instr_count += 1.
- rst pulsed during SW's MEM state → MemWrite drops the next cycle, state = FETCH, instr_count = 0, no NIA.
- OpFn = 11111 (HALT) → halted = 1 from cycle 3 and holds for 100 cycles with all strobes 0; rst → FETCH, halted = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_ADDI    = 3'd1,
        CL_LW      = 3'd2,
        CL_SW      = 3'd3,
        CL_BEQ     = 3'd4,
        CL_JMP     = 3'd5,
        CL_HALT    = 3'd6,
        CL_ILLEGAL = 3'd7
    } iclass_t;

    // Opcode constants (R-type is the whole 00xxx group)
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LW   = 5'b01001;
    localparam logic [4:0] OP_SW   = 5'b01010;
    localparam logic [4:0] OP_BEQ  = 5'b01011;
    localparam logic [4:0] OP_JMP  = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // ALU function codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    // Register write-destination select codes
    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_RD   = 3'b001;
    localparam logic [2:0] RD_RB   = 3'b010;

    // Classes whose ALU B operand is the sign-extended immediate
    function automatic logic uses_imm(input iclass_t cls);
        return (cls == CL_ADDI) || (cls == CL_LW) || (cls == CL_SW);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> instruction class and ALU function.
import ctrl_pkg::*;

module ctrl_decode #(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] op,
    output iclass_t        cls,
    output logic [2:0]     alufn
);

    // Classify the opcode and pick the ALU operation it needs
    always_comb begin
        cls   = CL_ILLEGAL;
        alufn = ALU_ADD;
        if (op[OPW-1:3] == '0) begin
            cls   = CL_RTYPE;
            alufn = op[2:0];
        end else if (op == OPW'(OP_ADDI)) begin
            cls   = CL_ADDI;
            alufn = ALU_ADD;
        end else if (op == OPW'(OP_LW)) begin
            cls   = CL_LW;
            alufn = ALU_ADD;
        end else if (op == OPW'(OP_SW)) begin
            cls   = CL_SW;
            alufn = ALU_ADD;
        end else if (op == OPW'(OP_BEQ)) begin
            cls   = CL_BEQ;
            alufn = ALU_SUB;
        end else if (op == OPW'(OP_JMP)) begin
            cls   = CL_JMP;
            alufn = ALU_ADD;
        end else if (op == OPW'(OP_HALT)) begin
            cls   = CL_HALT;
            alufn = ALU_ADD;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// every datapath strobe, plus halt, illegal-opcode flag and retire counter.
import ctrl_pkg::*;

module control_fsm #(
    parameter int OPW     = 5,
    parameter int MEM_LAT = 1,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  OpFn,
    input  logic            alubeq,
    output logic            NIA,
    output logic            Branch,
    output logic            Jump,
    output logic [2:0]      RegDst,
    output logic            RegWrite,
    output logic            ALUSrc,
    output logic [2:0]      ALUFn,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemToReg,
    output logic            halted,
    output logic            illegal_op,
    output logic [CNTW-1:0] instr_count
);

    localparam int          MCW      = 4;
    localparam logic [MCW-1:0] MEM_LOAD = MCW'(MEM_LAT - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [OPW-1:0]  r_op_q;
    logic [OPW-1:0]  w_op_next;
    logic [MCW-1:0]  r_mem_cnt;
    logic [MCW-1:0]  w_mem_cnt_next;
    logic [CNTW-1:0] r_instr_count;
    logic [CNTW-1:0] w_instr_count_next;

    logic [OPW-1:0]  w_dec_op;
    iclass_t         w_cls;
    logic [2:0]      w_alufn;

    // The decoder looks at the live opcode only while in DECODE; every later
    // state works from the captured copy so OpFn may change freely.
    assign w_dec_op = (r_state == DECODE) ? OpFn : r_op_q;

    ctrl_decode #(
        .OPW (OPW)
    ) u_decode (
        .op    (w_dec_op),
        .cls   (w_cls),
        .alufn (w_alufn)
    );

    // State, captured opcode, MEM latency counter and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_op_q        <= '0;
            r_mem_cnt     <= '0;
            r_instr_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_op_q        <= w_op_next;
            r_mem_cnt     <= w_mem_cnt_next;
            r_instr_count <= w_instr_count_next;
        end
    end

    // Next-state and strobe generation; all outputs default low each cycle
    always_comb begin
        w_state_next   = r_state;
        w_op_next      = r_op_q;
        w_mem_cnt_next = r_mem_cnt;
        NIA            = 1'b0;
        Branch         = 1'b0;
        Jump           = 1'b0;
        RegDst         = RD_NONE;
        RegWrite       = 1'b0;
        ALUSrc         = 1'b0;
        ALUFn          = ALU_ADD;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        MemToReg       = 1'b0;
        halted         = 1'b0;
        illegal_op     = 1'b0;

        case (r_state)
            FETCH: begin
                w_state_next = DECODE;
            end

            DECODE: begin
                w_op_next = OpFn;
                case (w_cls)
                    CL_ILLEGAL: begin
                        // Retire as a NOP so the program keeps moving
                        illegal_op   = 1'b1;
                        NIA          = 1'b1;
                        w_state_next = FETCH;
                    end
                    CL_HALT: w_state_next = HALT;
                    default: w_state_next = EXEC;
                endcase
            end

            EXEC: begin
                ALUFn  = w_alufn;
                ALUSrc = uses_imm(w_cls);
                case (w_cls)
                    CL_BEQ: begin
                        Branch       = alubeq;
                        NIA          = 1'b1;
                        w_state_next = FETCH;
                    end
                    CL_JMP: begin
                        ALUFn        = ALU_ADD;
                        Jump         = 1'b1;
                        NIA          = 1'b1;
                        w_state_next = FETCH;
                    end
                    CL_LW, CL_SW: begin
                        w_mem_cnt_next = MEM_LOAD;
                        w_state_next   = MEM;
                    end
                    default: w_state_next = WB;
                endcase
            end

            MEM: begin
                // Address stays on the ALU for the whole memory access
                ALUFn    = w_alufn;
                ALUSrc   = uses_imm(w_cls);
                MemRead  = (w_cls == CL_LW);
                MemWrite = (w_cls == CL_SW);
                if (r_mem_cnt == '0) begin
                    if (w_cls == CL_SW) begin
                        NIA          = 1'b1;
                        w_state_next = FETCH;
                    end else begin
                        w_state_next = WB;
                    end
                end else begin
                    w_mem_cnt_next = r_mem_cnt - 1'b1;
                end
            end

            WB: begin
                // ALU controls stay put so the written result is stable
                ALUFn    = w_alufn;
                ALUSrc   = uses_imm(w_cls);
                RegWrite = 1'b1;
                NIA      = 1'b1;
                case (w_cls)
                    CL_RTYPE: RegDst = RD_RD;
                    CL_ADDI:  RegDst = RD_RB;
                    CL_LW: begin
                        RegDst   = RD_RB;
                        MemToReg = 1'b1;
                        MemRead  = 1'b1;
                    end
                    default:  RegDst = RD_NONE;
                endcase
                w_state_next = FETCH;
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    // Every PC advance retires one instruction; wraps silently
    always_comb begin
        w_instr_count_next = r_instr_count + CNTW'(NIA);
    end

    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm (MEM_LAT = 3).
module tb_control_fsm;

    logic        clk;
    logic        rst;
    logic [4:0]  OpFn;
    logic        alubeq;
    logic        NIA, Branch, Jump, RegWrite, ALUSrc;
    logic [2:0]  RegDst, ALUFn;
    logic        MemRead, MemWrite, MemToReg, halted, illegal_op;
    logic [15:0] instr_count;

    int checks;
    int failures;
    logic [15:0] exp_cnt;
    logic        prev_nia;
    logic [14:0] strobes;

    assign strobes = {NIA, Branch, Jump, RegDst, RegWrite, ALUSrc, ALUFn,
                      MemRead, MemWrite, MemToReg, illegal_op};

    control_fsm #(
        .OPW     (5),
        .MEM_LAT (3),
        .CNTW    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .OpFn        (OpFn),
        .alubeq      (alubeq),
        .NIA         (NIA),
        .Branch      (Branch),
        .Jump        (Jump),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrc      (ALUSrc),
        .ALUFn       (ALUFn),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants checked every cycle on the falling edge
    always @(negedge clk) begin
        checks++;
        if (NIA && prev_nia) begin
            failures++;
            $display("FAIL inv_nia_consecutive got=%b%b want=not both", prev_nia, NIA);
        end
        checks++;
        if (RegWrite && MemWrite) begin
            failures++;
            $display("FAIL inv_regwrite_memwrite got=11 want=not both");
        end
        checks++;
        if (Branch && Jump) begin
            failures++;
            $display("FAIL inv_branch_jump got=11 want=not both");
        end
        prev_nia = NIA;
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (strobes !== 15'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b want=0000/0", strobes, halted);
        end
        checks++;
        if (instr_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", instr_count);
        end
        rst = 1'b0;
        exp_cnt = 16'd0;
        $display("txn reset");
    endtask

    task automatic test_rtype_sub();
        OpFn = 5'b00001;
        checks++;
        if (strobes !== 15'd0) begin
            failures++;
            $display("FAIL sub_fetch got=%h want=0000", strobes);
        end
        tick();
        checks++;
        if ({NIA, illegal_op, RegWrite} !== 3'b000) begin
            failures++;
            $display("FAIL sub_decode got=%b want=000", {NIA, illegal_op, RegWrite});
        end
        tick();
        OpFn = 5'b01100; // must be ignored now that the opcode is captured
        #1;
        checks++;
        if ({ALUFn, ALUSrc, RegWrite, NIA, Jump} !== 7'b001_0_0_0_0) begin
            failures++;
            $display("FAIL sub_exec got=%b want=0010000", {ALUFn, ALUSrc, RegWrite, NIA, Jump});
        end
        tick();
        checks++;
        if ({RegWrite, RegDst, NIA, MemToReg, MemWrite} !== 7'b1_001_1_0_0) begin
            failures++;
            $display("FAIL sub_wb got=%b want=1001100", {RegWrite, RegDst, NIA, MemToReg, MemWrite});
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (instr_count !== exp_cnt || NIA !== 1'b0) begin
            failures++;
            $display("FAIL sub_retire got=%0d/%b want=%0d/0", instr_count, NIA, exp_cnt);
        end
        $display("txn SUB count=%0d", instr_count);
    endtask

    task automatic test_addi();
        OpFn = 5'b01000;
        tick();
        tick();
        checks++;
        if ({ALUFn, ALUSrc, NIA} !== 5'b000_1_0) begin
            failures++;
            $display("FAIL addi_exec got=%b want=00010", {ALUFn, ALUSrc, NIA});
        end
        tick();
        checks++;
        if ({RegWrite, RegDst, NIA, MemToReg} !== 6'b1_010_1_0) begin
            failures++;
            $display("FAIL addi_wb got=%b want=101010", {RegWrite, RegDst, NIA, MemToReg});
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (instr_count !== exp_cnt) begin
            failures++;
            $display("FAIL addi_retire got=%0d want=%0d", instr_count, exp_cnt);
        end
        $display("txn ADDI count=%0d", instr_count);
    endtask

    task automatic test_lw();
        OpFn = 5'b01001;
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (MemRead !== (c >= 4) || NIA !== (c == 7) || MemWrite !== 1'b0) begin
                failures++;
                $display("FAIL lw_cycle%0d got=rd%b nia%b wr%b want=rd%b nia%b wr0",
                         c, MemRead, NIA, MemWrite, (c >= 4), (c == 7));
            end
            if (c == 3) begin
                checks++;
                if ({ALUFn, ALUSrc} !== 4'b000_1) begin
                    failures++;
                    $display("FAIL lw_exec got=%b want=0001", {ALUFn, ALUSrc});
                end
            end
            if (c == 7) begin
                checks++;
                if ({RegWrite, RegDst, MemToReg} !== 5'b1_010_1) begin
                    failures++;
                    $display("FAIL lw_wb got=%b want=10101", {RegWrite, RegDst, MemToReg});
                end
            end
            tick();
        end
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (instr_count !== exp_cnt || MemRead !== 1'b0 || NIA !== 1'b0) begin
            failures++;
            $display("FAIL lw_retire got=%0d/%b/%b want=%0d/0/0", instr_count, MemRead, NIA, exp_cnt);
        end
        $display("txn LW count=%0d", instr_count);
    endtask

    task automatic test_sw();
        OpFn = 5'b01010;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (MemWrite !== (c >= 4) || NIA !== (c == 6) || RegWrite !== 1'b0) begin
                failures++;
                $display("FAIL sw_cycle%0d got=wr%b nia%b rw%b want=wr%b nia%b rw0",
                         c, MemWrite, NIA, RegWrite, (c >= 4), (c == 6));
            end
            tick();
        end
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (instr_count !== exp_cnt || MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL sw_retire got=%0d/%b want=%0d/0", instr_count, MemWrite, exp_cnt);
        end
        $display("txn SW count=%0d", instr_count);
    endtask

    task automatic test_beq(input logic eq);
        OpFn   = 5'b01011;
        alubeq = eq;
        tick();
        checks++;
        if (NIA !== 1'b0) begin
            failures++;
            $display("FAIL beq%0d_decode got=%b want=0", eq, NIA);
        end
        tick();
        checks++;
        if ({Branch, Jump, NIA, RegWrite, ALUFn, ALUSrc} !== {eq, 7'b0_1_0_001_0}) begin
            failures++;
            $display("FAIL beq%0d_exec got=%b want=%b", eq,
                     {Branch, Jump, NIA, RegWrite, ALUFn, ALUSrc}, {eq, 7'b0_1_0_001_0});
        end
        tick();
        alubeq = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (instr_count !== exp_cnt || NIA !== 1'b0 || Branch !== 1'b0) begin
            failures++;
            $display("FAIL beq%0d_retire got=%0d/%b/%b want=%0d/0/0", eq, instr_count, NIA, Branch, exp_cnt);
        end
        $display("txn BEQ alubeq=%b count=%0d", eq, instr_count);
    endtask

    task automatic test_jmp();
        OpFn = 5'b01100;
        tick();
        tick();
        checks++;
        if ({Branch, Jump, NIA, RegWrite, MemWrite} !== 5'b0_1_1_0_0) begin
            failures++;
            $display("FAIL jmp_exec got=%b want=01100", {Branch, Jump, NIA, RegWrite, MemWrite});
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (instr_count !== exp_cnt || Jump !== 1'b0) begin
            failures++;
            $display("FAIL jmp_retire got=%0d/%b want=%0d/0", instr_count, Jump, exp_cnt);
        end
        $display("txn JMP count=%0d", instr_count);
    endtask

    task automatic test_illegal();
        OpFn = 5'b10101;
        tick();
        checks++;
        if ({illegal_op, NIA, RegWrite, MemWrite, MemRead} !== 5'b11000) begin
            failures++;
            $display("FAIL illegal_decode got=%b want=11000", {illegal_op, NIA, RegWrite, MemWrite, MemRead});
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (instr_count !== exp_cnt || illegal_op !== 1'b0 || NIA !== 1'b0) begin
            failures++;
            $display("FAIL illegal_retire got=%0d/%b/%b want=%0d/0/0", instr_count, illegal_op, NIA, exp_cnt);
        end
        $display("txn ILLEGAL count=%0d", instr_count);
    endtask

    task automatic test_reset_abort();
        OpFn = 5'b01010;
        tick();
        tick();
        tick();
        checks++;
        if (MemWrite !== 1'b1 || NIA !== 1'b0) begin
            failures++;
            $display("FAIL abort_mem got=%b/%b want=1/0", MemWrite, NIA);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (strobes !== 15'd0) begin
            failures++;
            $display("FAIL abort_strobes got=%h want=0000", strobes);
        end
        checks++;
        if (instr_count !== 16'd0) begin
            failures++;
            $display("FAIL abort_count got=%0d want=0", instr_count);
        end
        rst = 1'b0;
        exp_cnt = 16'd0;
        tick();
        checks++;
        if (NIA !== 1'b0 || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart got=%b/%b want=0/0", NIA, illegal_op);
        end
        $display("txn SW aborted by reset");
        // Return to FETCH cleanly for the next scenario
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_halt();
        OpFn = 5'b11111;
        tick();
        checks++;
        if (halted !== 1'b0 || NIA !== 1'b0) begin
            failures++;
            $display("FAIL halt_decode got=%b/%b want=0/0", halted, NIA);
        end
        tick();
        OpFn = 5'b00000;
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (halted !== 1'b1 || strobes !== 15'd0 || instr_count !== exp_cnt) begin
                failures++;
                $display("FAIL halt_hold%0d got=%b/%h/%0d want=1/0000/%0d",
                         c, halted, strobes, instr_count, exp_cnt);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b0 || strobes !== 15'd0 || instr_count !== 16'd0) begin
            failures++;
            $display("FAIL halt_reset got=%b/%h/%0d want=0/0000/0", halted, strobes, instr_count);
        end
        rst = 1'b0;
        exp_cnt = 16'd0;
        $display("txn HALT then reset");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prev_nia = 1'b0;
        rst      = 1'b1;
        OpFn     = 5'b00000;
        alubeq   = 1'b0;
        exp_cnt  = 16'd0;
        test_reset();
        test_rtype_sub();
        test_addi();
        test_lw();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jmp();
        test_illegal();
        test_reset_abort();
        test_halt();
        test_rtype_sub();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
